imm_extend_queue: RTL and testbench

Parametrised immediate-extension unit with an output queue, the successor to the fixed 16→32 sign extender in the decode path. Each accepted immediate is extended according to a per-transaction mode: sign, zero, upper-placement or scaled branch offset. The result is stored in a DEPTH-entry FIFO and presented on a valid/ready output port. It sits between instruction decode and the operand/branch-target stage and decouples decode from downstream stalls.

---
 rtl/imm_extend_queue.sv | 113 +++++++++++
 tb/tb_imm_extend_queue.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_queue.sv
`default_nettype none
// ============================================================================
// Module      : imm_extend_queue
// Description : Immediate extender (sign / zero / upper / scaled branch)
//               feeding a DEPTH-entry valid/ready output FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_extend_queue #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int SHIFT = 2,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [IN_W-1:0]            in_value,
    input  logic [1:0]                 in_mode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           out_value,
    output logic [1:0]                 out_mode,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] MODE_SIGN   = 2'b00;
    localparam logic [1:0] MODE_ZERO   = 2'b01;
    localparam logic [1:0] MODE_UPPER  = 2'b10;
    localparam logic [1:0] MODE_BRANCH = 2'b11;

    logic [OUT_W-1:0] mem      [DEPTH];
    logic [1:0]       mode_mem [DEPTH];

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_r;

    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] upper;
    logic [OUT_W-1:0] ext;
    logic             push;
    logic             pop;

    // Ready depends on rst_n directly so the source sees backpressure during reset
    assign in_ready  = rst_n && (count_r < CW'(DEPTH));
    assign out_valid = (count_r != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = count_r;

    // Head entry is masked to zero whenever the queue is empty
    assign out_value = out_valid ? mem[rd_ptr]      : '0;
    assign out_mode  = out_valid ? mode_mem[rd_ptr] : '0;

    // Build every extension variant and select by mode
    always_comb begin
        sext                 = {OUT_W{in_value[IN_W-1]}};
        sext[IN_W-1:0]       = in_value;
        zext                 = '0;
        zext[IN_W-1:0]       = in_value;
        upper                = '0;
        upper[OUT_W-1 -: IN_W] = in_value;
        ext                  = sext;
        case (in_mode)
            MODE_SIGN:   ext = sext;
            MODE_ZERO:   ext = zext;
            MODE_UPPER:  ext = upper;
            MODE_BRANCH: ext = sext << SHIFT;
            default:     ext = sext;
        endcase
    end

    // Entry storage; contents are don't-care until the pointers make them visible
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr]      <= ext;
            mode_mem[wr_ptr] <= in_mode;
        end
    end

    // Pointer and occupancy tracking; flush overrides any push or pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imm_extend_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_extend_queue
// Description : Directed self-checking bench for imm_extend_queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_extend_queue;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_value;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_value;
    logic [1:0]  out_mode;
    logic [2:0]  count;

    int checks;
    int errors;

    imm_extend_queue #(
        .IN_W  (16),
        .OUT_W (32),
        .SHIFT (2),
        .DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_value  (in_value),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_value (out_value),
        .out_mode  (out_mode),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past one rising edge and settle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_value  = '0;
        in_mode   = '0;
        out_ready = 1'b0;
        #2;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++;
        if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++;
        if (out_value !== 32'h0) begin errors++; $display("FAIL reset_out_value got %h exp 0", out_value); end
        step();
        step();
        #2 rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got %b exp 1", in_ready); end
        step();
    endtask

    task automatic test_modes();
        logic [15:0] vin  [6];
        logic [1:0]  vmode[6];
        logic [31:0] vexp [6];
        vin[0] = 16'h2710; vmode[0] = 2'b00; vexp[0] = 32'h00002710;
        vin[1] = 16'hE100; vmode[1] = 2'b00; vexp[1] = 32'hFFFFE100;
        vin[2] = 16'hE100; vmode[2] = 2'b01; vexp[2] = 32'h0000E100;
        vin[3] = 16'hE100; vmode[3] = 2'b10; vexp[3] = 32'hE1000000;
        vin[4] = 16'hFFFF; vmode[4] = 2'b11; vexp[4] = 32'hFFFFFFFC;
        vin[5] = 16'h0004; vmode[5] = 2'b11; vexp[5] = 32'h00000010;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_value = vin[i];
            in_mode  = vmode[i];
            step();
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL mode_out_valid[%0d] got %b exp 1", i, out_valid); end
            checks++;
            if (out_value !== vexp[i]) begin errors++; $display("FAIL mode_value[%0d] got %h exp %h", i, out_value, vexp[i]); end
            checks++;
            if (out_mode !== vmode[i]) begin errors++; $display("FAIL mode_out_mode[%0d] got %b exp %b", i, out_mode, vmode[i]); end
            checks++;
            if (count !== 3'd1) begin errors++; $display("FAIL mode_count[%0d] got %0d exp 1", i, count); end
            step();
            checks++;
            if (count !== 3'd0) begin errors++; $display("FAIL mode_drain_count[%0d] got %0d exp 0", i, count); end
        end
    endtask

    task automatic test_full_backpressure();
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1;
            in_value = 16'(i);
            in_mode  = 2'b01;
            checks++;
            if (in_ready !== (i <= 4)) begin errors++; $display("FAIL full_in_ready[%0d] got %b exp %b", i, in_ready, (i <= 4)); end
            if (i <= 4) step();
        end
        checks++;
        if (count !== 3'd4) begin errors++; $display("FAIL full_count got %0d exp 4", count); end
        checks++;
        if (out_value !== 32'd1) begin errors++; $display("FAIL full_head got %h exp 1", out_value); end
        out_ready = 1'b1;
        step();
        checks++;
        if (count !== 3'd3 || out_value !== 32'd2 || in_ready !== 1'b1) begin
            errors++; $display("FAIL full_pop1 got count %0d value %h ready %b exp 3 2 1", count, out_value, in_ready);
        end
        step();
        in_valid = 1'b0;
        for (int v = 3; v <= 5; v++) begin
            checks++;
            if (out_valid !== 1'b1 || out_value !== 32'(v) || count !== 3'(6 - v)) begin
                errors++; $display("FAIL full_drain[%0d] got valid %b value %h count %0d exp 1 %h %0d", v, out_valid, out_value, count, v, 6 - v);
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0 || out_value !== 32'h0) begin
            errors++; $display("FAIL full_empty got valid %b count %0d value %h exp 0 0 0", out_valid, count, out_value);
        end
    endtask

    task automatic test_wrap();
        out_ready = 1'b0;
        in_mode   = 2'b01;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_value = 16'(16'h0100 + i);
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_value = 16'(16'h0102 + i);
            checks++;
            if (out_value !== 32'(32'h0100 + i)) begin errors++; $display("FAIL wrap_value[%0d] got %h exp %h", i, out_value, 32'h0100 + i); end
            step();
            checks++;
            if (count !== 3'd2) begin errors++; $display("FAIL wrap_count[%0d] got %0d exp 2", i, count); end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (out_value !== 32'(32'h010A + i)) begin errors++; $display("FAIL wrap_tail[%0d] got %h exp %h", i, out_value, 32'h010A + i); end
            step();
        end
        checks++;
        if (count !== 3'd0) begin errors++; $display("FAIL wrap_end_count got %0d exp 0", count); end
    endtask

    task automatic test_full_pop_only();
        out_ready = 1'b0;
        in_mode   = 2'b00;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_value = 16'(16'h0010 + i);
            step();
        end
        in_value  = 16'h0099;
        out_ready = 1'b1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL popfull_in_ready got %b exp 0", in_ready); end
        step();
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd3 || in_ready !== 1'b1 || out_value !== 32'h11) begin
            errors++; $display("FAIL popfull_after got count %0d ready %b value %h exp 3 1 11", count, in_ready, out_value);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_value !== 32'(32'h11 + i)) begin errors++; $display("FAIL popfull_drain[%0d] got %h exp %h", i, out_value, 32'h11 + i); end
            step();
        end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL popfull_empty got %b exp 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_mode   = 2'b01;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_value = 16'(16'h0200 + i);
            step();
        end
        flush     = 1'b1;
        in_value  = 16'h02FF;
        out_ready = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || out_value !== 32'h0) begin
            errors++; $display("FAIL flush_clear got count %0d valid %b value %h exp 0 0 0", count, out_valid, out_value);
        end
        step();
        step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost got valid %b value %h exp 0", out_valid, out_value); end
        in_valid = 1'b1;
        in_value = 16'h0005;
        in_mode  = 2'b00;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_value !== 32'h5 || count !== 3'd1) begin
            errors++; $display("FAIL flush_recover got value %h count %0d exp 5 1", out_value, count);
        end
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_mode   = 2'b01;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_value = 16'(16'h0300 + i);
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd2) begin errors++; $display("FAIL rstmid_pre_count got %0d exp 2", count); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0 || out_value !== 32'h0 || out_mode !== 2'b00) begin
            errors++; $display("FAIL rstmid_async got valid %b count %0d value %h mode %b exp 0 0 0 0", out_valid, count, out_value, out_mode);
        end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_in_ready got %b exp 0", in_ready); end
        step();
        #2 rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_release_ready got %b exp 1", in_ready); end
        step();
        in_valid = 1'b1;
        in_value = 16'h8000;
        in_mode  = 2'b00;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_value !== 32'hFFFF8000 || count !== 3'd1) begin
            errors++; $display("FAIL rstmid_push got value %h count %0d exp ffff8000 1", out_value, count);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_modes();
        test_full_backpressure();
        test_wrap();
        test_full_pop_only();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case the run ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
`default_nettype wire
